// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - nibble-serial adder sequencer driving one shared 4-bit RCA
// Accepts an operand pair, walks the external RCA LSB nibble first, returns the registered sum.
module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  input  logic             i_cin_in,
  output logic [3:0]       o_rca_a,
  output logic [3:0]       o_rca_b,
  output logic             o_rca_cin,
  input  logic [3:0]       i_rca_sum,
  input  logic             i_rca_cout,
  output logic [WIDTH-1:0] o_sum_out,
  output logic             o_cout_out,
  output logic             o_ovf_out,
  output logic             o_done_valid,
  input  logic             i_done_ready,
  output logic             o_busy
);

  localparam int NSTEP = WIDTH / 4;
  localparam int IDXW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout_out;
  logic             r_ovf_out;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_full;

  assign w_last     = (r_idx == IDXW'(NSTEP - 1));
  // Lower nibbles are already in r_sum when the top nibble arrives from the RCA.
  assign w_sum_full = {i_rca_sum, r_sum[WIDTH-5:0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
      r_ovf_out  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start_valid) begin
            r_a     <= i_a_in;
            r_b     <= i_b_in;
            r_carry <= i_cin_in;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= i_rca_sum;
          r_carry                    <= i_rca_cout;
          r_idx                      <= r_idx + 1'b1;
          if (w_last) begin
            // Result registers only change here, so they survive until the next completion.
            r_sum_out  <= w_sum_full;
            r_cout_out <= i_rca_cout;
            r_ovf_out  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (i_rca_sum[3] != r_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    o_rca_a   = 4'd0;
    o_rca_b   = 4'd0;
    o_rca_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start_valid) w_next = S_RUN;
      end
      S_RUN: begin
        o_rca_a   = r_a[{r_idx, 2'b00} +: 4];
        o_rca_b   = r_b[{r_idx, 2'b00} +: 4];
        o_rca_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (i_done_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_start_ready = (r_state == S_IDLE);
  assign o_done_valid  = (r_state == S_DONE);
  assign o_busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign o_sum_out     = r_sum_out;
  assign o_cout_out    = r_cout_out;
  assign o_ovf_out     = r_ovf_out;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - self-checking bench for rca_seq_ctrl with an ideal 4-bit RCA
module tb_rca_seq_ctrl;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic [3:0]   rca_a, rca_b, rca_sum;
  logic         rca_cin, rca_cout;
  logic [W-1:0] sum_out;
  logic         cout_out, ovf_out, done_valid, busy;
  logic         done_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {4'd0, rca_cin};

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_start_valid(start_valid), .o_start_ready(start_ready),
    .i_a_in(a_in), .i_b_in(b_in), .i_cin_in(cin_in),
    .o_rca_a(rca_a), .o_rca_b(rca_b), .o_rca_cin(rca_cin),
    .i_rca_sum(rca_sum), .i_rca_cout(rca_cout),
    .o_sum_out(sum_out), .o_cout_out(cout_out), .o_ovf_out(ovf_out),
    .o_done_valid(done_valid), .i_done_ready(done_ready), .o_busy(busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry entering nibble i, from plain addition of the bits below it.
  function automatic logic carry_in_nib(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int i);
    int mask;
    int s;
    mask = (1 << (4 * i)) - 1;
    s = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    return ((s >> (4 * i)) & 1) != 0;
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int lat;
    start_valid = 1'b1;
    a_in = a;
    b_in = b;
    cin_in = c;
    chk("start_ready_idle", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in = W'($urandom);
    b_in = W'($urandom);
    cin_in = 1'($urandom);
    lat = 1;
    while (!done_valid && lat < 20) begin
      if (lat <= NS) begin
        chk("rca_a", rca_a, (a >> (4 * (lat - 1))) & 16'h000F);
        chk("rca_b", rca_b, (b >> (4 * (lat - 1))) & 16'h000F);
        chk("rca_cin", rca_cin, carry_in_nib(a, b, c, lat - 1));
        chk("busy_run", busy, 1);
      end
      done_ready = 1'($urandom);
      start_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    done_ready = 1'b0;
    start_valid = 1'b0;
    chk("latency", lat, NS + 1);
  endtask

  task automatic finish_op(input logic [W-1:0] s, input logic co, input logic ov, input int hold);
    for (int k = 0; k <= hold; k++) begin
      chk("done_valid", done_valid, 1);
      chk("sum_out", sum_out, s);
      chk("cout_out", cout_out, co);
      chk("ovf_out", ovf_out, ov);
      chk("start_ready_done", start_ready, 0);
      chk("rca_a_done", rca_a, 0);
      if (k < hold) begin
        start_valid = 1'($urandom);
        a_in = W'($urandom);
        @(posedge clk); #1;
      end
    end
    done_ready = 1'b1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("done_after_take", done_valid, 0);
    chk("start_ready_after", start_ready, 1);
    chk("busy_after", busy, 0);
    chk("sum_held", sum_out, s);
  endtask

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ra, rb, es;
    logic         rc, eo;
    int           seen;

    vecs[0] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[2] = '{16'hAAAA, 16'hFFFF, 1'b0, 16'hAAA9, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", cout_out, 0);
    chk("rst_ovf", ovf_out, 0);
    chk("rst_rca", {rca_a, rca_b, rca_cin}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      finish_op(vecs[i].s, vecs[i].co, vecs[i].ov, 0);
    end

    // Backpressure: result held seven cycles while operands and start_valid wiggle.
    launch(16'hAAAA, 16'hFFFF, 1'b0);
    finish_op(16'hAAA9, 1'b1, 1'b0, 7);

    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      es = full[W-1:0];
      eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
      launch(ra, rb, rc);
      finish_op(es, full[W], eo, int'($urandom_range(0, 3)));
    end

    // Reset on the second RUN cycle aborts the operation.
    launch(16'h7FFF, 16'h0001, 1'b0);
    finish_op(16'h8000, 1'b0, 1'b1, 0);
    start_valid = 1'b1;
    a_in = 16'hFFFF;
    b_in = 16'h0001;
    cin_in = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_before_abort", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_start_ready", start_ready, 1);
    chk("abort_done_valid", done_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum_out, 0);
    chk("abort_cout", cout_out, 0);
    chk("abort_ovf", ovf_out, 0);
    chk("abort_rca", {rca_a, rca_b, rca_cin}, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_valid) seen++;
    end
    chk("abort_no_done", seen, 0);
    launch(16'h1234, 16'h1111, 1'b0);
    finish_op(16'h2345, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
